// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one external system bus between the fetch path (M0)
// and the data path (M1), one outstanding transaction at a time.
// Flow: IDLE -> ADDR (command phase) -> RESP (response phase) -> IDLE.
// Fetch responses can be killed after a pipeline flush, and a cycle counter
// aborts a hung transaction with an error response.
// Optional feature: define BUS_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed priority with M1 over M0.
module sysbus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  // fetch master (M0)
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_kill,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  // data master (M1)
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  // external bus
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err,
  // status
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT_CYCLES);

  state_t            state;
  logic [TCNT_W-1:0] tcnt;
  logic              killed;
  logic              grant_m1;
  logic              timeout_hit;
  logic              resp_hit;
  logic              done;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

`ifdef BUS_ARB_RR_EN
  logic rr_last;  // 0 = M0 won last, 1 = M1 won last

  // Round-robin: on contention the master that did not win last time goes.
  always_comb begin
    grant_m1 = m1_req && (!m0_req || !rr_last);
  end
`else
  // Fixed priority: M1 (data) always beats M0 (fetch).
  always_comb begin
    grant_m1 = m1_req;
  end
`endif

  // Completion and response steering; bus response takes precedence over timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      timeout_hit = (state != IDLE) && (tcnt == TCNT_LIMIT);
    end
    resp_hit  = (state == RESP) && bus_rvalid;
    done      = resp_hit || timeout_hit;
    rsp_err   = resp_hit ? bus_err : 1'b1;
    rsp_data  = resp_hit ? bus_rdata : '0;

    // A flushed fetch is dropped whether the kill came earlier or arrives now.
    m0_rvalid = done && !owner && !killed && !m0_kill;
    m1_rvalid = done && owner;
    m0_rdata  = m0_rvalid ? rsp_data : '0;
    m1_rdata  = m1_rvalid ? rsp_data : '0;
    m0_err    = m0_rvalid && rsp_err;
    m1_err    = m1_rvalid && rsp_err;

    // A timeout in the command phase withdraws the command without acceptance.
    bus_valid = (state == ADDR) && !timeout_hit;
    busy      = (state != IDLE);
  end

  // Transaction FSM with latched bus payload, grant pulses, kill flag and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      killed    <= 1'b0;
      tcnt      <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
`ifdef BUS_ARB_RR_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      case (state)
        IDLE: begin
          tcnt   <= '0;
          killed <= 1'b0;
          if (m0_req || m1_req) begin
            state  <= ADDR;
            owner  <= grant_m1;
            m0_gnt <= !grant_m1;
            m1_gnt <= grant_m1;
`ifdef BUS_ARB_RR_EN
            rr_last <= grant_m1;
`endif
            if (grant_m1) begin
              bus_we    <= m1_we;
              bus_addr  <= m1_addr;
              bus_wdata <= m1_wdata;
              bus_wstrb <= m1_wstrb;
            end else begin
              // fetches are always plain reads
              bus_we    <= 1'b0;
              bus_addr  <= m0_addr;
              bus_wdata <= '0;
              bus_wstrb <= '0;
            end
          end
        end
        ADDR, RESP: begin
          if (TIMEOUT_CYCLES != 0) begin
            tcnt <= tcnt + TCNT_W'(1);
          end
          if (!owner && m0_kill) begin
            killed <= 1'b1;
          end
          if (done) begin
            state <= IDLE;
          end else if (state == ADDR && bus_ready) begin
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
